// File: rtl/hwpe_stream_prbs_checker_if.sv
// HWPE-Stream handshake bundle: data/strb qualified by valid, accepted on valid & ready.
// Pure wiring with no latency; the sink drives ready and the source must hold data while stalled.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_prbs_checker.sv
// PRBS stream sink: checks each accepted beat byte-wise (strobe-masked) against a local PRBS copy.
// Latency: counters update one cycle after a handshake, and the verdict appears the cycle after the last beat.
// Backpressure: ready is a pure flop function (stall LFSR vs threshold in RUN) and never depends on valid.
module hwpe_stream_prbs_checker #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NB_BEATS_WIDTH = 16,
    parameter logic [31:0] SEED           = 32'h0000_0001,
    parameter logic [7:0]  STALL_THRESH   = 8'd0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [NB_BEATS_WIDTH-1:0] nb_beats_i,
    hwpe_stream_intf_stream.sink      push_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      pass_o,
    output logic [15:0]               err_cnt_o,
    output logic [NB_BEATS_WIDTH-1:0] first_err_idx_o,
    output logic [NB_BEATS_WIDTH-1:0] beat_cnt_o
);

    localparam int unsigned NB_BYTES   = DATA_WIDTH / 8;
    localparam logic [31:0] SEED_N     = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] PRBS_POLY  = 32'h8020_0003;
    localparam logic [15:0] STALL_INIT = 16'hACE1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q;
    logic [31:0]               prbs_q;
    logic [15:0]               stall_q;
    logic [NB_BEATS_WIDTH-1:0] target_q;

    logic        stall_ok;
    logic        ready;
    logic        hs;
    logic        mismatch;
    logic        last_beat;
    logic        stall_fb;
    logic [31:0] prbs_next;

    // A zero threshold would make the compare trivially true, so it is resolved at elaboration.
    generate
        if (STALL_THRESH == 8'd0) begin : g_no_stall
            assign stall_ok = 1'b1;
        end else begin : g_stall
            assign stall_ok = (stall_q[7:0] >= STALL_THRESH);
        end
    endgenerate

    assign ready        = (state_q == RUN) && stall_ok;
    assign push_i.ready = ready;
    assign hs           = push_i.valid && ready;

    assign stall_fb  = stall_q[0] ^ stall_q[2] ^ stall_q[3] ^ stall_q[5];
    assign prbs_next = (prbs_q >> 1) ^ ({32{prbs_q[0]}} & PRBS_POLY);
    assign last_beat = (beat_cnt_o == (target_q - NB_BEATS_WIDTH'(1)));

    always_comb begin
        mismatch = 1'b0;
        for (int b = 0; b < NB_BYTES; b++) begin
            if (push_i.strb[b] && (push_i.data[8*b +: 8] != prbs_q[8*b +: 8])) begin
                mismatch = 1'b1;
            end
        end
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign pass_o = (state_q == DONE) && (err_cnt_o == 16'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            prbs_q          <= SEED_N;
            stall_q         <= STALL_INIT;
            target_q        <= '0;
            err_cnt_o       <= '0;
            beat_cnt_o      <= '0;
            first_err_idx_o <= '1;
        end else if (clear_i) begin
            state_q         <= IDLE;
            prbs_q          <= SEED_N;
            stall_q         <= STALL_INIT;
            target_q        <= '0;
            err_cnt_o       <= '0;
            beat_cnt_o      <= '0;
            first_err_idx_o <= '1;
        end else begin
            if (state_q == RUN) begin
                stall_q <= {stall_fb, stall_q[15:1]};
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        prbs_q          <= SEED_N;
                        target_q        <= nb_beats_i;
                        err_cnt_o       <= '0;
                        beat_cnt_o      <= '0;
                        first_err_idx_o <= '1;
                        state_q         <= (nb_beats_i == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (mismatch) begin
                            if (err_cnt_o != 16'hFFFF) begin
                                err_cnt_o <= err_cnt_o + 16'd1;
                            end
                            // Error count is only zero before the first mismatch of the run.
                            if (err_cnt_o == 16'd0) begin
                                first_err_idx_o <= beat_cnt_o;
                            end
                        end
                        beat_cnt_o <= beat_cnt_o + NB_BEATS_WIDTH'(1);
                        prbs_q     <= prbs_next;
                        if (last_beat) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hwpe_stream_prbs_checker.sv
// Bench for hwpe_stream_prbs_checker: two instances (no stall / threshold 128) share one source driver.
// Run verdicts go through scoreboard queues; a negedge monitor pops them when done_o rises.
module tb_hwpe_stream_prbs_checker;

    typedef struct packed {
        logic        pass;
        logic [15:0] err;
        logic [15:0] idx;
        logic [15:0] beats;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [15:0] nb;
    logic        sel;
    logic        vld;
    logic [31:0] dat;
    logic [3:0]  strb;
    logic        rdy;

    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0, idx0, beat0, err1, idx1, beat1;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls1  = 0;
    int hs1      = 0;
    int cyc      = 0;

    res_t q0[$];
    res_t q1[$];

    logic [31:0] good[4];

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s0 ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s1 ();

    assign s0.valid = vld & ~sel;
    assign s0.data  = dat;
    assign s0.strb  = strb;
    assign s1.valid = vld & sel;
    assign s1.data  = dat;
    assign s1.strb  = strb;
    assign rdy      = sel ? s1.ready : s0.ready;

    hwpe_stream_prbs_checker #(
        .DATA_WIDTH(32), .NB_BEATS_WIDTH(16), .SEED(32'h0000_0001), .STALL_THRESH(8'd0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start & ~sel),
        .nb_beats_i(nb), .push_i(s0),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(err0),
        .first_err_idx_o(idx0), .beat_cnt_o(beat0)
    );

    hwpe_stream_prbs_checker #(
        .DATA_WIDTH(32), .NB_BEATS_WIDTH(16), .SEED(32'h0000_0001), .STALL_THRESH(8'd128)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start & sel),
        .nb_beats_i(nb), .push_i(s1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
        .first_err_idx_o(idx1), .beat_cnt_o(beat1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got hung run, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic sb_check(input string tag, input res_t e, input logic p,
                            input logic [15:0] er, input logic [15:0] ix, input logic [15:0] bc);
        chk({tag, "_pass"}, {31'd0, p}, {31'd0, e.pass});
        chk({tag, "_err"}, {16'd0, er}, {16'd0, e.err});
        chk({tag, "_idx"}, {16'd0, ix}, {16'd0, e.idx});
        chk({tag, "_beats"}, {16'd0, bc}, {16'd0, e.beats});
    endtask

    // Scoreboard monitor: a rising done_o presents a verdict to compare.
    initial begin
        logic d0q, d1q;
        res_t e;
        d0q = 1'b0;
        d1q = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && !d0q) begin
                chk("sb0_pending", {31'd0, q0.size() != 0}, 32'd1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    sb_check("sb0", e, pass0, err0, idx0, beat0);
                end
            end
            if (done1 && !d1q) begin
                chk("sb1_pending", {31'd0, q1.size() != 0}, 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    sb_check("sb1", e, pass1, err1, idx1, beat1);
                end
            end
            d0q = done0;
            d1q = done1;
        end
    end

    always @(posedge clk) begin
        if (s1.valid && s1.ready) hs1++;
    end

    function automatic logic [31:0] prbs_step(input logic [31:0] x);
        return (x >> 1) ^ ({32{x[0]}} & 32'h8020_0003);
    endfunction

    // All stimulus tasks begin and end just after a falling edge.
    task automatic start_run(input logic which, input int n, input logic push, input res_t exp);
        sel   = which;
        nb    = 16'(n);
        start = 1'b1;
        if (push) begin
            if (which) q1.push_back(exp);
            else       q0.push_back(exp);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
        bit ok;
        ok   = 1'b0;
        vld  = 1'b1;
        dat  = d;
        strb = s;
        for (int k = 0; k < 100 && !ok; k++) begin
            if (rdy) ok = 1'b1;
            else if (sel) stalls1++;
            cyc++;
            @(negedge clk);
        end
        vld = 1'b0;
        if (!ok) chk("hs_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic send_four(input logic [31:0] d[4], input logic [3:0] s[4]);
        for (int i = 0; i < 4; i++) send_beat(d[i], s[i]);
    endtask

    initial begin
        logic [31:0] d[4];
        logic [3:0]  s[4];
        logic [31:0] x;

        good = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
        s    = '{4'hF, 4'hF, 4'hF, 4'hF};
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; nb = '0;
        sel = 1'b0; vld = 1'b0; dat = '0; strb = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        chk("rst_ready", {31'd0, rdy}, 32'd0);
        chk("rst_err", {16'd0, err0}, 32'd0);
        chk("rst_beats", {16'd0, beat0}, 32'd0);
        chk("rst_idx", {16'd0, idx0}, 32'h0000_FFFF);

        // Clean run, back-to-back.
        start_run(1'b0, 4, 1'b1, '{1'b1, 16'd0, 16'hFFFF, 16'd4});
        chk("start_busy", {31'd0, busy0}, 32'd1);
        cyc = 0;
        send_four(good, s);
        chk("clean_cycles", cyc, 32'd4);
        chk("clean_done_lat", {31'd0, done0}, 32'd1);
        chk("clean_ready_low", {31'd0, rdy}, 32'd0);

        // Corrupt beat 2, started straight from DONE.
        d = good; d[2] = 32'hC030_0003;
        start_run(1'b0, 4, 1'b1, '{1'b0, 16'd1, 16'd2, 16'd4});
        send_four(d, s);

        // Strobe masks the wrong top byte, then the same beat unmasked.
        d = good; d[1] = 32'hFF20_0003;
        s[1] = 4'b0111;
        start_run(1'b0, 4, 1'b1, '{1'b1, 16'd0, 16'hFFFF, 16'd4});
        send_four(d, s);
        s[1] = 4'b1111;
        start_run(1'b0, 4, 1'b1, '{1'b0, 16'd1, 16'd1, 16'd4});
        send_four(d, s);

        // Zero length.
        pulse_clear();
        start_run(1'b0, 0, 1'b1, '{1'b1, 16'd0, 16'hFFFF, 16'd0});
        chk("zero_done", {31'd0, done0}, 32'd1);
        chk("zero_pass", {31'd0, pass0}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("zero_ready", {31'd0, rdy}, 32'd0);
            @(negedge clk);
        end

        // Clear mid-run, coinciding with an offered beat.
        pulse_clear();
        start_run(1'b0, 4, 1'b0, '0);
        send_beat(good[0], 4'hF);
        send_beat(32'hDEAD_BEEF, 4'hF);
        chk("mid_err", {16'd0, err0}, 32'd1);
        chk("mid_idx", {16'd0, idx0}, 32'd1);
        clear = 1'b1; vld = 1'b1; dat = good[2]; strb = 4'hF;
        @(negedge clk);
        clear = 1'b0; vld = 1'b0;
        chk("clr_busy", {31'd0, busy0}, 32'd0);
        chk("clr_ready", {31'd0, rdy}, 32'd0);
        chk("clr_beats", {16'd0, beat0}, 32'd0);
        chk("clr_err", {16'd0, err0}, 32'd0);
        chk("clr_idx", {16'd0, idx0}, 32'h0000_FFFF);
        s = '{4'hF, 4'hF, 4'hF, 4'hF};
        start_run(1'b0, 4, 1'b1, '{1'b1, 16'd0, 16'hFFFF, 16'd4});
        send_four(good, s);

        // Asynchronous reset mid-run.
        start_run(1'b0, 4, 1'b0, '0);
        send_beat(good[0], 4'hF);
        send_beat(32'hDEAD_BEEF, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_ready", {31'd0, rdy}, 32'd0);
        chk("arst_beats", {16'd0, beat0}, 32'd0);
        chk("arst_err", {16'd0, err0}, 32'd0);
        chk("arst_idx", {16'd0, idx0}, 32'h0000_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(1'b0, 4, 1'b1, '{1'b1, 16'd0, 16'hFFFF, 16'd4});
        send_four(good, s);

        // Backpressure on the stalling instance.
        start_run(1'b1, 1000, 1'b1, '{1'b1, 16'd0, 16'hFFFF, 16'd1000});
        x = 32'h0000_0001;
        for (int i = 0; i < 1000; i++) begin
            send_beat(x, 4'hF);
            x = prbs_step(x);
        end
        chk("bp_done", {31'd0, done1}, 32'd1);
        vld = 1'b1; dat = x; strb = 4'hF;
        repeat (5) @(negedge clk);
        vld = 1'b0;
        chk("bp_handshakes", hs1, 32'd1000);
        chk("bp_ready_toggled", {31'd0, stalls1 != 0}, 32'd1);

        repeat (2) @(negedge clk);
        chk("sb0_drained", q0.size(), 32'd0);
        chk("sb1_drained", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_prbs_checker.md
# hwpe_stream_prbs_checker

Synthesizable, self-checking HWPE-Stream sink. It consumes a stream whose payload is a PRBS sequence and compares every accepted beat against its own copy of the same PRBS. It applies pseudo-random backpressure and reports a pass/fail verdict, an error count and the index of the first mismatch. It is the receiving end for FIFO, streamer and interconnect stress tests, usable on FPGA/silicon bring-up where no simulator reservoir exists.

## Interface
Parameters:
- DATA_WIDTH, 32, stream data width in bits; must be 8, 16, 24 or 32.
- NB_BEATS_WIDTH, 16, width of the beat-count fields.
- SEED, 32'h0000_0001, initial PRBS state; a value of 0 is replaced by 32'h0000_0001.
- STALL_THRESH, 0, 8-bit backpressure threshold; 0 means never stall, 255 means stall about 255/256 of cycles.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous soft clear, returns to IDLE.
- start_i  in  1  start a check run; sampled in IDLE or DONE.
- nb_beats_i  in  NB_BEATS_WIDTH  number of beats to check; sampled with start_i.
- push_i  sink  hwpe_stream_intf_stream (DATA_WIDTH)  incoming stream (data, strb, valid, ready).
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- pass_o  out  1  high in DONE when err_cnt_o == 0.
- err_cnt_o  out  16  number of mismatching beats, saturating at 16'hFFFF.
- first_err_idx_o  out  NB_BEATS_WIDTH  index of the first mismatching beat; all-ones if there is none.
- beat_cnt_o  out  NB_BEATS_WIDTH  beats accepted in the current run.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On start_i, load prbs <= SEED (0 is replaced by 1), load target <= nb_beats_i, and clear the counters.
  - Go to RUN, or to DONE if nb_beats_i == 0.
- RUN:
  - A handshake is valid & ready.
  - On each handshake, compare data against prbs[DATA_WIDTH-1:0], byte by byte, only on bytes whose strb bit is 1.
  - Any masked mismatch increments err_cnt_o (saturating). If it is the first error, latch first_err_idx_o <= beat_cnt_o.
  - Then beat_cnt_o++ and the PRBS advances.
  - The handshake with beat_cnt_o == target-1 moves the FSM to DONE.
- DONE:
  - ready = 0 and done_o = 1; results are held.
  - start_i begins a new run exactly as from IDLE.
- clear_i in any state:
  - Go to IDLE and clear the counters; first_err_idx_o returns to all-ones.
  - clear_i has priority over start_i and over a handshake in the same cycle.
- PRBS step: prbs_next = (prbs >> 1) ^ ({32{prbs[0]}} & 32'h8020_0003). It advances only on a handshake.
- Stall LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, reset/clear value 16'hACE1.
  - It shifts every cycle while in RUN and holds otherwise.
- ready = (state == RUN) && (stall[7:0] >= STALL_THRESH).
  - ready is a function of flops only, never of valid.
- The checker does not require valid to be stable, but a compliant source holds data/strb while valid & !ready.

## Timing
- Reset values: state IDLE, ready 0, busy_o 0, done_o 0, pass_o 0, err_cnt_o 0, beat_cnt_o 0, first_err_idx_o all-ones, prbs SEED (normalized), stall 16'hACE1.
- start_i at edge N: busy_o = 1 and ready can go high from cycle N+1.
- Result latency: err_cnt_o, first_err_idx_o and beat_cnt_o reflect a handshake one cycle after its edge.
- The last handshake at edge M gives done_o = 1 and pass_o valid in cycle M+1; ready = 0 from M+1.
- nb_beats_i == 0: done_o = 1 and pass_o = 1 in the cycle after start_i; ready is never asserted.
- STALL_THRESH = 0: ready stays at 1 throughout RUN, giving 1 beat/cycle sustained.
- Asynchronous reset mid-run: all outputs go immediately to their reset values, and no partial result is kept.
- beat_cnt_o does not wrap, because a run ends at target ≤ 2^NB_BEATS_WIDTH-1.

## Test plan
- Clean run: SEED=1, STALL_THRESH=0, nb_beats=4, source sends 0x00000001, 0x80200003, 0xC0300002, 0x60180001 back-to-back -> 4 handshakes in 4 cycles; done_o next cycle with pass_o=1, err_cnt_o=0, beat_cnt_o=4, first_err_idx_o=16'hFFFF.
- Corrupt beat: as above, but beat 2 is sent as 0xC0300003 -> err_cnt_o=1, first_err_idx_o=2, pass_o=0.
- Strobe masking: beat 1 is sent as 0xFF200003 with strb=4'b0111 -> no error, pass_o=1. The same beat with strb=4'b1111 -> err_cnt_o=1.
- Zero length: nb_beats=0 -> ready never high, done_o and pass_o both 1 one cycle after start_i.
- Backpressure: STALL_THRESH=128, nb_beats=1000, source holds valid high with the correct PRBS -> ready toggles; exactly 1000 handshakes; pass_o=1; no beat lost or duplicated.
- Clear/reset mid-run: clear_i after 2 beats -> IDLE next cycle, ready=0, counters 0, first_err_idx_o all-ones; a new start_i checks again from SEED. Repeat the run with rst_ni pulsed instead -> same result, with the outputs clearing asynchronously.
